id_stage: RTL
=============

ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 clk  input  1  single clock; all state on rising edge.
REQ-002 resetn  input  1  asynchronous, active-low reset.
REQ-003 IF_ID_valid  input  1  IF holds a valid instruction for ID.
REQ-004 IF_inst  input  32  instruction from IF.
REQ-005 IF_pc  input  32  PC of IF_inst.
REQ-006 ID_allow_in  output  1  ID accepts IF data this cycle.
REQ-007 br_taken  output  1  redirect IF; br_target  output  32  redirect address.
REQ-008 EX_allow_in  input  1  EX accepts ID data; ID_EX_valid  output  1  ID data to EX is valid.
REQ-009 rf_raddr1, rf_raddr2  output  5 each; rf_rdata1, rf_rdata2  input  32 each  combinational register-file read (r0 reads 0).
REQ-010 EX_dest, MEM_dest, WB_dest  input  5 each; EX_we, MEM_we, WB_we  input  1 each  downstream destination and valid-and-writes flags for interlock.
REQ-011 ID_EX_pc  output  32; ID_alu_op  output  2 (00 add, 01 sub, 10 pass src2); ID_src1, ID_src2  output  32; ID_rkd_value  output  32 store data.
REQ-012 ID_rf_we  output  1; ID_dest  output  5; ID_mem_we  output  1; ID_res_from_mem  output  1.

Function
REQ-013 Internal state: ID_valid (1b), ID_inst (32b), ID_pc (32b); all other outputs combinational from state and inputs.
REQ-014 ID_allow_in = ~ID_valid | (ID_ready_go & EX_allow_in); ID_EX_valid = ID_valid & ID_ready_go.
REQ-015 On ID_allow_in: ID_valid <= IF_ID_valid & ~br_taken; ID_inst/ID_pc load IF_inst/IF_pc; otherwise hold all state.
REQ-016 Decode (all others decode as NOP: rf_we=0, mem_we=0, no branch): add.w inst[31:15]=0x00020; sub.w 0x00020→0x00022; addi.w inst[31:22]=0x00A; ld.w 0x0A2; st.w 0x0A6; lu12i.w inst[31:25]=7'b0001010; jirl inst[31:26]=0x13; b 0x14; bl 0x15; beq 0x16; bne 0x17.
REQ-017 Fields: rd=inst[4:0], rj=inst[9:5], rk=inst[14:10]; si12=inst[21:10]; offs16=inst[25:10]; offs26={inst[9:0],inst[25:10]}; si20=inst[24:5]; all immediates sign-extended to 32b.
REQ-018 rf_raddr1=rj; rf_raddr2=rd for st.w/beq/bne, else rk.
REQ-019 Operands: src1 = ID_pc for bl/jirl, else rf_rdata1; src2 = sext(si12) for addi.w/ld.w/st.w, {si20,12'b0} for lu12i.w, 32'd4 for bl/jirl, else rf_rdata2; ID_rkd_value = rf_rdata2.
REQ-020 alu_op: sub for sub.w, pass-src2 for lu12i.w, add otherwise.
REQ-021 Dest: r1 for bl, rd otherwise; ID_rf_we = writer (add.w,sub.w,addi.w,ld.w,lu12i.w,bl,jirl) & dest!=0 & ID_valid.
REQ-022 ID_mem_we = st.w & ID_valid; ID_res_from_mem = ld.w.
REQ-023 Interlock: conflict when ID uses a read port (port1: all except b/bl/lu12i.w; port2: add.w,sub.w,st.w,beq,bne), its address !=0, and equals a dest of any stage with we=1; ID_ready_go = ~conflict.
REQ-024 Branch condition: beq rdata1==rdata2, bne !=, b/bl/jirl unconditional.
REQ-025 br_taken = ID_valid & ID_ready_go & EX_allow_in & condition; asserted for exactly the cycle the branch leaves ID.
REQ-026 br_target: jirl = rf_rdata1 + sext({offs16,2'b0}); b/bl = ID_pc + sext({offs26,2'b0}); beq/bne = ID_pc + sext({offs16,2'b0}); modulo 2^32; 0 when br_taken=0 is not required.
REQ-027 Stalled branch (conflict) SHALL NOT assert br_taken; it resolves with fresh operands once conflict clears.
REQ-028 Simultaneous br_taken and valid IF input: wrong-path instruction discarded (ID_valid <= 0).

Reset
REQ-029 resetn low: ID_valid=0, ID_inst=0, ID_pc=0 immediately, no clock needed; thus ID_EX_valid=0, br_taken=0, ID_allow_in=1, ID_rf_we=0, ID_mem_we=0.
REQ-030 Reset asserted mid-stall discards held instruction; first post-reset IF instruction accepted on first edge after resetn high.

Verification
REQ-031 add.w r3,r1,r2 (0x00100823), no conflicts, EX_allow_in=1 -> next cycle ID_EX_valid=1, dest=3, rf_we=1, alu_op=00, raddr1=1, raddr2=2.
REQ-032 ID holds add.w r3,r1,r2 with EX_dest=1, EX_we=1 -> ID_allow_in=0, ID_EX_valid=0; drop EX_we -> issues same cycle.
REQ-033 beq r1,r2,+8 at pc 0x1c000000, rdata1=rdata2=5 -> br_taken=1, br_target=0x1c000008; IF_ID_valid=1 same cycle -> ID_valid=0 next cycle.
REQ-034 bl offs26=-1 at pc 0x1c000010 -> br_target=0x1c00000c, dest=1, src1=0x1c000010, src2=4.
REQ-035 jirl r0,r1,0 with EX_allow_in=0 -> br_taken=0 until EX_allow_in=1, then target=rf_rdata1.
REQ-036 resetn pulsed low asynchronously while ID_valid=1 -> ID_EX_valid drops to 0 before next clock edge.

Source files
------------

// File: rtl/id_stage.sv
// id_stage: instruction-decode stage of a five-stage LoongArch-subset pipeline.
// Holds one instruction, decodes it, reads operands from the register file,
// interlocks against pending writes in EX/MEM/WB and resolves branches.
module id_stage (
  input  logic        clk,
  input  logic        resetn,
  input  logic        IF_ID_valid,
  input  logic [31:0] IF_inst,
  input  logic [31:0] IF_pc,
  output logic        ID_allow_in,
  output logic        br_taken,
  output logic [31:0] br_target,
  input  logic        EX_allow_in,
  output logic        ID_EX_valid,
  output logic [4:0]  rf_raddr1,
  output logic [4:0]  rf_raddr2,
  input  logic [31:0] rf_rdata1,
  input  logic [31:0] rf_rdata2,
  input  logic [4:0]  EX_dest,
  input  logic [4:0]  MEM_dest,
  input  logic [4:0]  WB_dest,
  input  logic        EX_we,
  input  logic        MEM_we,
  input  logic        WB_we,
  output logic [31:0] ID_EX_pc,
  output logic [1:0]  ID_alu_op,
  output logic [31:0] ID_src1,
  output logic [31:0] ID_src2,
  output logic [31:0] ID_rkd_value,
  output logic        ID_rf_we,
  output logic [4:0]  ID_dest,
  output logic        ID_mem_we,
  output logic        ID_res_from_mem
);

  logic        id_valid_r;
  logic [31:0] id_inst_r;
  logic [31:0] id_pc_r;

  logic inst_add_s, inst_sub_s, inst_addi_s, inst_ld_s, inst_st_s, inst_lu12i_s;
  logic inst_jirl_s, inst_b_s, inst_bl_s, inst_beq_s, inst_bne_s;
  logic [4:0]  rd_s, rj_s, rk_s;
  logic [31:0] si12_ext_s, lu12i_imm_s, offs16_ext_s, offs26_ext_s;
  logic        writer_s, uses1_s, uses2_s, conflict_s, ready_go_s, cond_s;

  // A read address collides with a stage that will write the same register.
  function automatic logic dest_hit(input logic [4:0] addr, input logic [4:0] dest,
                                    input logic we);
    return we & (addr == dest);
  endfunction

  // Opcode match and field extraction from the held instruction.
  always_comb begin
    inst_add_s   = (id_inst_r[31:15] == 17'h00020);
    inst_sub_s   = (id_inst_r[31:15] == 17'h00022);
    inst_addi_s  = (id_inst_r[31:22] == 10'h00A);
    inst_ld_s    = (id_inst_r[31:22] == 10'h0A2);
    inst_st_s    = (id_inst_r[31:22] == 10'h0A6);
    inst_lu12i_s = (id_inst_r[31:25] == 7'b0001010);
    inst_jirl_s  = (id_inst_r[31:26] == 6'h13);
    inst_b_s     = (id_inst_r[31:26] == 6'h14);
    inst_bl_s    = (id_inst_r[31:26] == 6'h15);
    inst_beq_s   = (id_inst_r[31:26] == 6'h16);
    inst_bne_s   = (id_inst_r[31:26] == 6'h17);
    rd_s         = id_inst_r[4:0];
    rj_s         = id_inst_r[9:5];
    rk_s         = id_inst_r[14:10];
    si12_ext_s   = {{20{id_inst_r[21]}}, id_inst_r[21:10]};
    lu12i_imm_s  = {id_inst_r[24:5], 12'h000};
    offs16_ext_s = {{14{id_inst_r[25]}}, id_inst_r[25:10], 2'b00};
    offs26_ext_s = {{4{id_inst_r[9]}}, id_inst_r[9:0], id_inst_r[25:10], 2'b00};
    writer_s     = inst_add_s | inst_sub_s | inst_addi_s | inst_ld_s |
                   inst_lu12i_s | inst_bl_s | inst_jirl_s;
    uses1_s      = ~(inst_b_s | inst_bl_s | inst_lu12i_s);
    uses2_s      = inst_add_s | inst_sub_s | inst_st_s | inst_beq_s | inst_bne_s;
  end

  // Register-file read addresses: stores and compares read rd on port 2.
  always_comb begin
    rf_raddr1 = rj_s;
    if (inst_st_s | inst_beq_s | inst_bne_s) begin
      rf_raddr2 = rd_s;
    end else begin
      rf_raddr2 = rk_s;
    end
  end

  // Read-after-write interlock against EX, MEM and WB destinations.
  always_comb begin
    conflict_s = 1'b0;
    if (uses1_s && (rf_raddr1 != 5'd0) &&
        (dest_hit(rf_raddr1, EX_dest, EX_we) | dest_hit(rf_raddr1, MEM_dest, MEM_we) |
         dest_hit(rf_raddr1, WB_dest, WB_we))) begin
      conflict_s = 1'b1;
    end else if (uses2_s && (rf_raddr2 != 5'd0) &&
        (dest_hit(rf_raddr2, EX_dest, EX_we) | dest_hit(rf_raddr2, MEM_dest, MEM_we) |
         dest_hit(rf_raddr2, WB_dest, WB_we))) begin
      conflict_s = 1'b1;
    end else begin
      conflict_s = 1'b0;
    end
    ready_go_s = ~conflict_s;
  end

  // Operand selection, ALU op and destination for the EX bundle.
  always_comb begin
    if (inst_bl_s | inst_jirl_s) begin
      ID_src1 = id_pc_r;
    end else begin
      ID_src1 = rf_rdata1;
    end
    if (inst_addi_s | inst_ld_s | inst_st_s) begin
      ID_src2 = si12_ext_s;
    end else if (inst_lu12i_s) begin
      ID_src2 = lu12i_imm_s;
    end else if (inst_bl_s | inst_jirl_s) begin
      ID_src2 = 32'd4;
    end else begin
      ID_src2 = rf_rdata2;
    end
    if (inst_sub_s) begin
      ID_alu_op = 2'b01;
    end else if (inst_lu12i_s) begin
      ID_alu_op = 2'b10;
    end else begin
      ID_alu_op = 2'b00;
    end
    if (inst_bl_s) begin
      ID_dest = 5'd1;
    end else begin
      ID_dest = rd_s;
    end
  end

  // Branch condition and target address (wraps modulo 2^32).
  always_comb begin
    if (inst_beq_s) begin
      cond_s = (rf_rdata1 == rf_rdata2);
    end else if (inst_bne_s) begin
      cond_s = (rf_rdata1 != rf_rdata2);
    end else begin
      cond_s = inst_b_s | inst_bl_s | inst_jirl_s;
    end
    if (inst_jirl_s) begin
      br_target = rf_rdata1 + offs16_ext_s;
    end else if (inst_b_s | inst_bl_s) begin
      br_target = id_pc_r + offs26_ext_s;
    end else begin
      br_target = id_pc_r + offs16_ext_s;
    end
  end

  assign ID_allow_in     = ~id_valid_r | (ready_go_s & EX_allow_in);
  assign ID_EX_valid     = id_valid_r & ready_go_s;
  assign br_taken        = id_valid_r & ready_go_s & EX_allow_in & cond_s;
  assign ID_EX_pc        = id_pc_r;
  assign ID_rkd_value    = rf_rdata2;
  assign ID_rf_we        = writer_s & (ID_dest != 5'd0) & id_valid_r;
  assign ID_mem_we       = inst_st_s & id_valid_r;
  assign ID_res_from_mem = inst_ld_s;

  // Pipeline register: accept from IF when allowed, dropping wrong-path fetches.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      id_valid_r <= 1'b0;
      id_inst_r  <= 32'h0000_0000;
      id_pc_r    <= 32'h0000_0000;
    end else if (ID_allow_in) begin
      id_valid_r <= IF_ID_valid & ~br_taken;
      id_inst_r  <= IF_inst;
      id_pc_r    <= IF_pc;
    end else begin
      id_valid_r <= id_valid_r;
      id_inst_r  <= id_inst_r;
      id_pc_r    <= id_pc_r;
    end
  end

endmodule
